// File: rtl/pool_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pool_ctrl_pkg
// Shared definitions for the layer controllers of the VGG16 accelerator:
//   - pool_state_e : state encoding of the pooling-layer sequencer
//   - calc_pix     : pixels in one WIDTH x HEIGHT feature map
//   - calc_opix    : pixels in the 2x2-pooled output map
//   - cnt_width    : counter width able to hold the value n (clog2(n)+1)
// -----------------------------------------------------------------------------
package pool_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } pool_state_e;

    function automatic int calc_pix(input int w, input int h);
        return w * h;
    endfunction

    function automatic int calc_opix(input int w, input int h);
        return (w * h) / 4;
    endfunction

    // Wide enough to hold n itself, not just n-1 (counters run to PIX/OPIX).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// -----------------------------------------------------------------------------
// pool_addr_gen
// Channel / read / result counters of the pooling sequencer and the buffer
// addresses derived from them.
//   clk, resetn     : clock, synchronous active-low reset
//   clr_ch_i        : restart at channel 0 (layer accepted)
//   inc_ch_i        : advance to the next channel
//   clr_cnt_i       : clear read and result counters (start of a channel)
//   inc_rd_i        : one input pixel read this cycle
//   inc_out_i       : one result written this cycle
//   ch_o, rd_cnt_o, out_cnt_o : current counter values
//   rd_addr_o       : ch*PIX  + rd_cnt
//   wr_addr_o       : ch*OPIX + out_cnt
// -----------------------------------------------------------------------------
module pool_addr_gen #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 16,
    localparam int PIX   = pool_ctrl_pkg::calc_pix(WIDTH, HEIGHT),
    localparam int OPIX  = pool_ctrl_pkg::calc_opix(WIDTH, HEIGHT),
    localparam int CH_W  = pool_ctrl_pkg::cnt_width(CHANNELS),
    localparam int CNT_W = pool_ctrl_pkg::cnt_width(PIX)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_ch_i,
    input  logic                  inc_ch_i,
    input  logic                  clr_cnt_i,
    input  logic                  inc_rd_i,
    input  logic                  inc_out_i,
    output logic [CH_W-1:0]       ch_o,
    output logic [CNT_W-1:0]      rd_cnt_o,
    output logic [CNT_W-1:0]      out_cnt_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o
);

    logic [CH_W-1:0]  ch_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] out_cnt_q;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ch_q      <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (clr_ch_i) begin
                ch_q <= '0;
            end else if (inc_ch_i) begin
                ch_q <= ch_q + 1'b1;
            end

            if (clr_cnt_i) begin
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (inc_rd_i)  rd_cnt_q  <= rd_cnt_q + 1'b1;
                if (inc_out_i) out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

    assign ch_o      = ch_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign out_cnt_o = out_cnt_q;

    // Parameter rule CHANNELS*PIX <= 2^ADDR_WIDTH keeps these products from wrapping.
    assign rd_addr_o = ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(PIX)  + ADDR_WIDTH'(rd_cnt_q);
    assign wr_addr_o = ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(OPIX) + ADDR_WIDTH'(out_cnt_q);

endmodule

// File: rtl/pool_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pool_layer_ctrl
// Sequencer for the max_pooling engine: runs one pooling layer channel by
// channel (clear engine, stream WIDTHxHEIGHT pixels, collect OPIX results).
//   clk, resetn              : clock, synchronous active-low reset
//   start                    : begin a layer (sampled only in IDLE)
//   busy, done, error        : status; done is a 1-cycle pulse, error is a
//                              sticky drain timeout cleared by the next start
//   rd_en, rd_addr, rd_data  : input buffer, data returns 1 cycle after rd_en
//   mp_resetn                : engine synchronous reset (low in CLEAR / reset)
//   mp_valid_in, mp_data_in  : pixel stream to the engine
//   mp_valid_out, mp_data_out: results from the engine
//   wr_en, wr_addr, wr_data  : output buffer write port
// -----------------------------------------------------------------------------
module pool_layer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DRAIN_MAX  = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mp_resetn,
    output logic                  mp_valid_in,
    output logic [DATA_WIDTH-1:0] mp_data_in,
    input  logic                  mp_valid_out,
    input  logic [DATA_WIDTH-1:0] mp_data_out,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    import pool_ctrl_pkg::*;

    localparam int PIX   = calc_pix(WIDTH, HEIGHT);
    localparam int OPIX  = calc_opix(WIDTH, HEIGHT);
    localparam int CH_W  = cnt_width(CHANNELS);
    localparam int CNT_W = cnt_width(PIX);
    localparam int DR_W  = cnt_width(DRAIN_MAX);

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(PIX - 1);
    localparam logic [CNT_W-1:0] OUT_FULL = CNT_W'(OPIX);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_MAX - 1);

    pool_state_e      state_q;
    logic             busy_q, done_q, error_q, rd_en_q, mp_valid_in_q;
    logic [DR_W-1:0]  drain_q;

    logic [CH_W-1:0]       ch;
    logic [CNT_W-1:0]      rd_cnt, out_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr_raw, wr_addr_raw;

    logic accept, wr_ok;

    assign accept = (state_q == S_IDLE) && start;

    // Results are only accepted while a channel is in flight and not yet full;
    // the write goes out combinationally so write latency equals engine latency.
    assign wr_ok = ((state_q == S_STREAM) || (state_q == S_DRAIN))
                   && mp_valid_out && (out_cnt < OUT_FULL);

    pool_addr_gen #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .CHANNELS   (CHANNELS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .resetn    (resetn),
        .clr_ch_i  (accept),
        .inc_ch_i  ((state_q == S_NEXT) && (ch != CH_LAST)),
        .clr_cnt_i (state_q == S_CLEAR),
        .inc_rd_i  (state_q == S_STREAM),
        .inc_out_i (wr_ok),
        .ch_o      (ch),
        .rd_cnt_o  (rd_cnt),
        .out_cnt_o (out_cnt),
        .rd_addr_o (rd_addr_raw),
        .wr_addr_o (wr_addr_raw)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            mp_valid_in_q <= 1'b0;
            drain_q       <= '0;
        end else begin
            done_q        <= 1'b0;
            mp_valid_in_q <= rd_en_q;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_STREAM;
                    rd_en_q <= 1'b1;
                end
                S_STREAM: begin
                    if (rd_cnt == RD_LAST) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                    end
                end
                S_DRAIN: begin
                    // A complete channel wins over a timeout landing in the same cycle.
                    if (out_cnt == OUT_FULL) begin
                        state_q <= S_NEXT;
                    end else if (drain_q == DR_LAST) begin
                        state_q <= S_DONE;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (ch == CH_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_en_q ? rd_addr_raw : '0;
    assign mp_valid_in = mp_valid_in_q;
    assign mp_data_in  = mp_valid_in_q ? rd_data : '0;

    // Combinational with resetn so the engine is cleared on the same edge as we are.
    assign mp_resetn   = resetn && (state_q != S_CLEAR);

    assign wr_en       = wr_ok;
    assign wr_addr     = wr_ok ? wr_addr_raw : '0;
    assign wr_data     = wr_ok ? mp_data_out : '0;

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool_layer_ctrl
// Directed bench for pool_layer_ctrl (4x4 maps, 2 channels, DRAIN_MAX 64) with
// a behavioural 2x2 max-pooling engine and a 1-cycle-latency input buffer.
// -----------------------------------------------------------------------------
module tb_pool_layer_ctrl;

    localparam int DW  = 32;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int CH  = 2;
    localparam int AW  = 16;
    localparam int DM  = 64;
    localparam int PIX = W * H;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          mp_resetn, mp_valid_in;
    logic [DW-1:0] mp_data_in;
    logic          mp_valid_out;
    logic [DW-1:0] mp_data_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    pool_layer_ctrl #(
        .DATA_WIDTH (DW),
        .WIDTH      (W),
        .HEIGHT     (H),
        .CHANNELS   (CH),
        .ADDR_WIDTH (AW),
        .DRAIN_MAX  (DM)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .mp_resetn    (mp_resetn),
        .mp_valid_in  (mp_valid_in),
        .mp_data_in   (mp_data_in),
        .mp_valid_out (mp_valid_out),
        .mp_data_out  (mp_data_out),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    // ---------------- input buffer: 0..63 raster, 1-cycle read latency -------
    logic [DW-1:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = DW'(i);

    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[5:0]] : '0;

    // ---------------- behavioural 2x2 max-pooling engine ---------------------
    logic [DW-1:0] rowbuf [0:W/2-1];
    logic [DW-1:0] tmp_max = '0;
    logic [DW-1:0] eng_d = '0;
    logic          eng_v = 1'b0;
    int            col_q = 0;
    int            row_q = 0;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (!mp_resetn) begin
            col_q <= 0;
            row_q <= 0;
            eng_v <= 1'b0;
            eng_d <= '0;
        end else begin
            eng_v <= 1'b0;
            if (mp_valid_in) begin
                if (row_q % 2 == 0) begin
                    rowbuf[col_q/2] <= (col_q % 2 == 0) ? mp_data_in
                                                        : max2(rowbuf[col_q/2], mp_data_in);
                end else if (col_q % 2 == 0) begin
                    tmp_max <= max2(rowbuf[col_q/2], mp_data_in);
                end else begin
                    eng_d <= max2(tmp_max, mp_data_in);
                    eng_v <= 1'b1;
                end
                col_q <= (col_q == W - 1) ? 0 : col_q + 1;
                if (col_q == W - 1) row_q <= (row_q == H - 1) ? 0 : row_q + 1;
            end
        end
    end

    // Stub override: lets a test silence the engine or inject spurious results.
    logic stub_en = 1'b0;
    logic stub_v  = 1'b0;
    assign mp_valid_out = stub_en ? stub_v : eng_v;
    assign mp_data_out  = stub_en ? DW'(32'hBAD0_0BAD) : eng_d;

    // ---------------- checking ----------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, " busy"},        64'(busy),        64'd0);
        check({pfx, " done"},        64'(done),        64'd0);
        check({pfx, " error"},       64'(error),       64'd0);
        check({pfx, " rd_en"},       64'(rd_en),       64'd0);
        check({pfx, " mp_valid_in"}, 64'(mp_valid_in), 64'd0);
        check({pfx, " wr_en"},       64'(wr_en),       64'd0);
        check({pfx, " rd_addr"},     64'(rd_addr),     64'd0);
        check({pfx, " wr_addr"},     64'(wr_addr),     64'd0);
        check({pfx, " mp_data_in"},  64'(mp_data_in),  64'd0);
        check({pfx, " wr_data"},     64'(wr_data),     64'd0);
        check({pfx, " mp_resetn"},   64'(mp_resetn),   64'd0);
    endtask

    // ---------------- per-layer observation ---------------------------------
    int            rd_cycles, rd_first, run0_len, lag_bad, data_bad;
    int            wr_count, wr_bad_addr, done_cnt, done_cycle, err_cycle;
    logic          busy_after_done, err_at1, err_end;
    logic [DW-1:0] out_mem [0:7];

    // Pulses start (E0 = the edge that samples it) and observes cycles 1..budget
    // at the falling edge; start is re-raised during cycle poke_cycle if >0.
    task automatic run_layer(input int budget, input int poke_cycle);
        logic          prev_rd   = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          gap       = 1'b0;
        rd_cycles = 0; rd_first = -1; run0_len = 0; lag_bad = 0; data_bad = 0;
        wr_count = 0; wr_bad_addr = 0; done_cnt = 0; done_cycle = -1; err_cycle = -1;
        busy_after_done = 1'b1; err_at1 = 1'b1; err_end = 1'b0;
        for (int i = 0; i < 8; i++) out_mem[i] = '1;

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = (k == poke_cycle);
            if (rd_en) begin
                rd_cycles++;
                if (rd_first < 0) rd_first = k;
                if (!gap) run0_len++;
            end else if (rd_first >= 0) begin
                gap = 1'b1;
            end
            if (mp_valid_in !== prev_rd) lag_bad++;
            if (mp_valid_in && (mp_data_in !== prev_data)) data_bad++;
            prev_rd   = rd_en;
            prev_data = mem[rd_addr[5:0]];
            if (wr_en) begin
                wr_count++;
                if (wr_addr < 8) out_mem[wr_addr[2:0]] = wr_data;
                else wr_bad_addr++;
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (done_cycle >= 0 && k == done_cycle + 1) busy_after_done = busy;
            if (k == 1) err_at1 = error;
            if (error && err_cycle < 0) err_cycle = k;
            err_end = error;
            if (done_cycle >= 0 && k >= done_cycle + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic check_nominal(input string pfx);
        logic [DW-1:0] exp_out [0:7];
        exp_out = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd21, 32'd23, 32'd29, 32'd31};
        for (int i = 0; i < 8; i++)
            check($sformatf("%s out[%0d]", pfx, i), 64'(out_mem[i]), 64'(exp_out[i]));
        check({pfx, " write count"},  64'(wr_count),    64'd8);
        check({pfx, " bad wr_addr"},  64'(wr_bad_addr), 64'd0);
        check({pfx, " done count"},   64'(done_cnt),    64'd1);
        check({pfx, " done cycle"},   64'(done_cycle),  64'd43);
        check({pfx, " busy after"},   64'(busy_after_done), 64'd0);
        check({pfx, " error"},        64'(err_end),     64'd0);
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        int cnt_done;
        int cnt_wr;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle mp_resetn", 64'(mp_resetn), 64'd1);

        // Nominal layer plus stream timing
        run_layer(200, -1);
        check("rd_en first cycle", 64'(rd_first),  64'd2);
        check("rd_en ch0 run",     64'(run0_len),  64'(PIX));
        check("rd_en total",       64'(rd_cycles), 64'(CH * PIX));
        check("valid_in lag",      64'(lag_bad),   64'd0);
        check("mp_data_in",        64'(data_bad),  64'd0);
        check_nominal("nominal");

        // Start while busy (ch1 STREAM spans cycles 23..38)
        run_layer(200, 30);
        check_nominal("start busy");

        // Drain timeout: engine silent
        stub_en = 1'b1;
        stub_v  = 1'b0;
        run_layer(300, -1);
        check("timeout error cycle", 64'(err_cycle), 64'(2 + PIX + DM));
        check("timeout done cycle",  64'(done_cycle), 64'(2 + PIX + DM));
        check("timeout done count",  64'(done_cnt),  64'd1);
        check("timeout writes",      64'(wr_count),  64'd0);
        check("timeout sticky",      64'(err_end),   64'd1);
        stub_en = 1'b0;

        // Next start clears error
        run_layer(200, -1);
        check("error cleared", 64'(err_at1), 64'd0);
        check_nominal("after timeout");

        // Reset mid-layer during ch0 STREAM
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid rd_en before reset", 64'(rd_en), 64'd1);
        resetn = 1'b0;
        #1;
        check("mp_resetn during reset", 64'(mp_resetn), 64'd0);
        @(negedge clk);
        check_reset_vals("mid reset");
        resetn = 1'b1;
        cnt_done = 0;
        cnt_wr   = 0;
        repeat (60) begin
            @(negedge clk);
            if (done)  cnt_done++;
            if (wr_en) cnt_wr++;
        end
        check("abort done count",  64'(cnt_done), 64'd0);
        check("abort write count", 64'(cnt_wr),   64'd0);
        run_layer(200, -1);
        check_nominal("after reset");

        // Spurious engine output while IDLE
        stub_en = 1'b1;
        stub_v  = 1'b1;
        cnt_wr  = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en) cnt_wr++;
        end
        check("idle spurious writes", 64'(cnt_wr), 64'd0);
        check("idle busy",            64'(busy),   64'd0);
        stub_en = 1'b0;
        stub_v  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
